johnson_decoder: RTL and testbench
==================================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter: WIDTH, default 4, number of Johnson code bits (N); the code space is 2N states.
REQ-002 Parameter: LOCK_LEN, default 3, number of consecutive correct steps required to lock.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  jc_in is sampled on this edge.
REQ-006 Port: jc_in  input  WIDTH  received Johnson code.
REQ-007 Port: out_valid  output  1  one-cycle pulse; idx/onehot are updated from a legal sample.
REQ-008 Port: idx  output  clog2(2N)  decoded state index, 0..2N-1.
REQ-009 Port: onehot  output  2N  one-hot form of idx.
REQ-010 Port: illegal  output  1  one-cycle pulse; the sample was not a Johnson code.
REQ-011 Port: seq_err  output  1  one-cycle pulse; while locked, the sample was not idx+1 mod 2N.
REQ-012 Port: locked  output  1  level; the sequence tracker is in the LOCKED state.
REQ-013 Port: err_cnt  output  8  saturating error counter.

Function
REQ-014 Legal code, msb=0: the ones are contiguous from the LSB (including all-zero). Legal code, msb=1: the ones are contiguous from the MSB (including all-ones). Every other code is illegal.
REQ-015 Index decode: idx = msb ? 2N - popcount : popcount (N=4: 0000->0, 0111->3, 1111->4, 1000->7).
REQ-016 All outputs are registered; latency is 1 cycle from the sampling edge.
REQ-017 When in_valid=0: no state changes, and out_valid, illegal and seq_err are 0.
REQ-018 Legal sample: out_valid=1; idx and onehot are updated; the sample becomes the reference (ref_idx), and have_ref is set to 1.
REQ-019 Illegal sample: illegal=1, out_valid=0, idx/onehot hold; have_ref=0, run=0, state->UNLOCKED, err_cnt increments.
REQ-020 Correct step: a legal sample with have_ref=1 and idx equal to (ref_idx+1) mod 2N. The wrap from 2N-1 to 0 is a correct step.
REQ-021 FSM states: UNLOCKED and LOCKED.
REQ-022 UNLOCKED, correct step: run increments; when run reaches LOCK_LEN, the state goes to LOCKED and locked=1 on that same update.
REQ-023 UNLOCKED, legal non-step sample: run=0, no seq_err.
REQ-024 LOCKED, correct step: the state stays LOCKED.
REQ-025 LOCKED, legal non-step sample (including a repeat of the same code): seq_err=1, state->UNLOCKED, run=0, err_cnt increments, and the sample becomes the new reference.
REQ-026 err_cnt saturates at 255 and never wraps.
REQ-027 illegal and seq_err are never both 1 in the same cycle.

Reset
REQ-028 rst=0 forces the following immediately, regardless of clk: idx=0, onehot=0, out_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0, have_ref=0, run=0, state=UNLOCKED.
REQ-029 A reset asserted mid-stream discards all history; the first sample after reset release is treated as having no reference.

Configuration
REQ-030 Macro JDEC_ERRCNT_EN defined: err_cnt is implemented per REQ-026.
REQ-031 Macro JDEC_ERRCNT_EN undefined: err_cnt is tied to 0, and no counter flops are present; all other behaviour is unchanged.

Verification (WIDTH=4, LOCK_LEN=3, JDEC_ERRCNT_EN defined unless noted)
REQ-032 Apply reset, then in_valid=1 with 0000,0001,0011,0111 -> idx=0,1,2,3 each one cycle later; locked rises with idx=3; no error pulses.
REQ-033 While locked, continue 1111,1110,1100,1000,0000 -> idx=4,5,6,7,0; locked stays 1; seq_err stays 0 across the 7->0 wrap.
REQ-034 While locked at idx=3, apply 1110 -> seq_err=1 for one cycle, idx=5, locked=0, err_cnt=1; then apply 1100,1000,0000 -> locked=1 again.
REQ-035 Apply 0101 -> illegal=1, out_valid=0, idx holds, locked=0, err_cnt increments; then apply 0001 -> out_valid=1, idx=1, no seq_err.
REQ-036 Drive rst low between clock edges while locked with err_cnt=2 -> all outputs are 0 before the next edge; then 0011 after release -> idx=2, locked=0.
REQ-037 Apply 300 illegal samples -> err_cnt=255 and holds; rerun with JDEC_ERRCNT_EN undefined -> err_cnt stays 0 throughout.

Source files
------------

// File: rtl/johnson_decoder.sv
// Johnson code decoder with sequence lock tracking.
// Each valid sample is checked for legality, decoded to a state index and
// one-hot vector, and compared against the previous legal sample. After
// LOCK_LEN consecutive +1 steps the tracker locks; a wrong step while locked
// raises seq_err. Define JDEC_ERRCNT_EN to build the saturating error counter;
// without it err_cnt is tied to zero and no counter flops exist.
module johnson_decoder #(
   parameter int  WIDTH    = 4,
   parameter int  LOCK_LEN = 3,
   localparam int STATES   = 2 * WIDTH,
   localparam int IDX_W    = $clog2(STATES),
   localparam int RUN_W    = $clog2(LOCK_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   jc_in,
   output logic               out_valid,
   output logic [IDX_W-1:0]   idx,
   output logic [STATES-1:0]  onehot,
   output logic               illegal,
   output logic               seq_err,
   output logic               locked,
   output logic [7:0]         err_cnt
);

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   localparam logic [WIDTH-1:0]  W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [STATES-1:0] OH_ONE  = {{(STATES-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(STATES - 1);
   localparam logic [RUN_W-1:0]  RUN_ONE = RUN_W'(1);
   localparam logic [RUN_W-1:0]  RUN_LCK = RUN_W'(LOCK_LEN);

   state_t             state_q, state_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               have_ref_q, have_ref_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [STATES-1:0]  onehot_q, onehot_d;
   logic               out_valid_q, out_valid_d;
   logic               illegal_q, illegal_d;
   logic               seq_err_q, seq_err_d;

   logic               msb;
   logic [WIDTH-1:0]   norm;
   logic               legal;
   logic [IDX_W-1:0]   dec_idx;
   logic [IDX_W-1:0]   next_ref;
   logic               step;
   int                 pop;

   // Legality and index decode. Folding msb=1 codes by inversion turns both
   // legal shapes into "ones contiguous from the LSB", i.e. a 2^k-1 value.
   always_comb begin
      msb  = jc_in[WIDTH-1];
      norm = msb ? ~jc_in : jc_in;
      legal = ((norm & (norm + W_ONE)) == '0);
      pop = 0;
      for (int i = 0; i < WIDTH; i++) pop += int'(jc_in[i]);
      dec_idx = msb ? IDX_W'(STATES - pop) : IDX_W'(pop);
   end

   // The last legal index is always held in idx_q, so it doubles as the
   // reference; have_ref says whether it is meaningful.
   always_comb begin
      next_ref = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      step     = have_ref_q && (dec_idx == next_ref);
   end

   // Next-state logic for the tracker and the registered outputs.
   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      have_ref_d  = have_ref_q;
      idx_d       = idx_q;
      onehot_d    = onehot_q;
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
      seq_err_d   = 1'b0;
      if (in_valid) begin
         if (!legal) begin
            illegal_d  = 1'b1;
            have_ref_d = 1'b0;
            run_d      = '0;
            state_d    = UNLOCKED;
         end else begin
            out_valid_d = 1'b1;
            idx_d       = dec_idx;
            onehot_d    = OH_ONE << dec_idx;
            have_ref_d  = 1'b1;
            if (state_q == LOCKED) begin
               if (!step) begin
                  seq_err_d = 1'b1;
                  state_d   = UNLOCKED;
                  run_d     = '0;
               end
            end else if (step) begin
               run_d = run_q + RUN_ONE;
               if (run_q + RUN_ONE == RUN_LCK) state_d = LOCKED;
            end else begin
               run_d = '0;
            end
         end
      end
   end

   // Tracker state and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= UNLOCKED;
         run_q       <= '0;
         have_ref_q  <= 1'b0;
         idx_q       <= '0;
         onehot_q    <= '0;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         have_ref_q  <= have_ref_d;
         idx_q       <= idx_d;
         onehot_q    <= onehot_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
         seq_err_q   <= seq_err_d;
      end
   end

`ifdef JDEC_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_inc;

   // Count illegal samples and sequence errors, sticking at 255.
   always_comb begin
      err_inc   = illegal_d | seq_err_d;
      err_cnt_d = err_cnt_q;
      if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_cnt_q <= '0;
      else      err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

   assign out_valid = out_valid_q;
   assign idx       = idx_q;
   assign onehot    = onehot_q;
   assign illegal   = illegal_q;
   assign seq_err   = seq_err_q;
   assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (WIDTH=4, LOCK_LEN=3). The driver
// updates a table-driven reference model and queues the expected outputs;
// a monitor pops one entry per sampled cycle and compares.
module tb_johnson_decoder;
   localparam int W  = 4;
   localparam int LL = 3;
   localparam int S  = 2 * W;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] jc_in;
   logic         out_valid;
   logic [2:0]   idx;
   logic [S-1:0] onehot;
   logic         illegal;
   logic         seq_err;
   logic         locked;
   logic [7:0]   err_cnt;

   johnson_decoder #(.WIDTH(W), .LOCK_LEN(LL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .jc_in(jc_in),
      .out_valid(out_valid), .idx(idx), .onehot(onehot), .illegal(illegal),
      .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ov; bit ill; bit se; bit lk;
      int idx; int oh; int err;
   } exp_t;

   exp_t q[$];
   exp_t m_e;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_idx, m_oh, m_err, m_run;
   bit m_lk, m_have;

   // Johnson code for state k: k ones from the LSB up to k=W, then
   // 2W-k ones from the MSB.
   function automatic logic [W-1:0] code_of(input int k);
      int v;
      if (k <= W) v = (1 << k) - 1;
      else        v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
      return v[W-1:0];
   endfunction

   function automatic int jdec(input logic [W-1:0] c);
      for (int k = 0; k < S; k++) if (code_of(k) == c) return k;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic bump_err();
`ifdef JDEC_ERRCNT_EN
      if (m_err < 255) m_err++;
`endif
   endtask

   task automatic model_reset();
      m_idx = 0; m_oh = 0; m_err = 0; m_run = 0; m_lk = 0; m_have = 0;
   endtask

   task automatic drive(input bit v, input logic [W-1:0] c);
      exp_t e;
      int   k;
      bit   step;
      @(negedge clk);
      in_valid = v;
      jc_in    = c;
      e.ov = 0; e.ill = 0; e.se = 0;
      if (v) begin
         k = jdec(c);
         if (k < 0) begin
            e.ill = 1; m_have = 0; m_run = 0; m_lk = 0; bump_err();
         end else begin
            e.ov = 1;
            step = m_have && (k == (m_idx + 1) % S);
            if (m_lk) begin
               if (!step) begin e.se = 1; m_lk = 0; m_run = 0; bump_err(); end
            end else if (step) begin
               m_run++;
               if (m_run == LL) m_lk = 1;
            end else begin
               m_run = 0;
            end
            m_idx = k; m_oh = 1 << k; m_have = 1;
         end
      end
      e.lk = m_lk; e.idx = m_idx; e.oh = m_oh; e.err = m_err;
      q.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_idx"},       idx,       0);
      chk({tag, "_onehot"},    onehot,    0);
      chk({tag, "_illegal"},   illegal,   0);
      chk({tag, "_seq_err"},   seq_err,   0);
      chk({tag, "_locked"},    locked,    0);
      chk({tag, "_err_cnt"},   err_cnt,   0);
   endtask

   // Reset asserted between edges; outputs must clear before the next edge.
   task automatic mid_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Monitor: one expected entry per sampled cycle.
   always @(posedge clk) begin
      #1;
      if (rst && q.size() > 0) begin
         m_e = q.pop_front();
         chk("out_valid", out_valid, int'(m_e.ov));
         chk("illegal",   illegal,   int'(m_e.ill));
         chk("seq_err",   seq_err,   int'(m_e.se));
         chk("locked",    locked,    int'(m_e.lk));
         chk("idx",       idx,       m_e.idx);
         chk("onehot",    onehot,    m_e.oh);
         chk("err_cnt",   err_cnt,   m_e.err);
         chk("ill_seq_exclusive", illegal & seq_err, 0);
      end
   end

   initial begin
      logic [W-1:0] seq1 [0:8];
      logic [W-1:0] c;
      int r;
      seq1 = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
               4'b1110, 4'b1100, 4'b1000, 4'b0000};
      rst = 1'b0; in_valid = 1'b0; jc_in = '0;
      model_reset();
      #2;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // lock-up and full wrap while locked
      for (int i = 0; i < 9; i++) drive(1, seq1[i]);
      // relock at 3, skip to 5, then relock
      drive(1, 4'b0001); drive(1, 4'b0011); drive(1, 4'b0111);
      drive(1, 4'b1110);
      drive(1, 4'b1100); drive(1, 4'b1000); drive(1, 4'b0000);
      drive(0, 4'b1010);
      // illegal then restart without reference
      drive(1, 4'b0101); drive(1, 4'b0001);
      // lock again, then async reset mid-stream
      drive(1, 4'b0011); drive(1, 4'b0111); drive(1, 4'b1111);
      mid_reset();
      drive(1, 4'b0011);
      drive(1, 4'b0111);

      // randomized mix
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)       c = code_of((m_idx + 1) % S);
         else if (r == 6) c = code_of(m_idx);
         else if (r == 7) c = code_of($urandom_range(0, S - 1));
         else             c = W'($urandom_range(0, 15));
         drive(r != 9, c);
      end

      // saturation of the error counter
      for (int i = 0; i < 300; i++) drive(1, (i % 2) ? 4'b0101 : 4'b1011);
      drive(1, 4'b0000); drive(1, 4'b0001); drive(1, 4'b1000);

      drive(0, 4'b0000);
      drive(0, 4'b0000);
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
